// File: rtl/message_fifo_reader.sv
// message_fifo_reader: drains length-prefixed frames from the message FIFO and
// presents them one byte at a time to a valid/ready sink with SOF/EOF flags.
module message_fifo_reader #(
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_frame_valid,
    output logic        fifo_data_latch,
    input  logic        flush,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FRM_W  = 16;

    localparam logic [CNT_W-1:0] RL_THR     = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] SETTLE_THR = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        PRESENT = 3'd2,
        GAP     = 3'd3,
        SETTLE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                flush_frame_q, flush_frame_d;
    logic [BYTE_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]   rem_q, rem_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_sat;
    logic [BYTE_W-1:0]   hold_d;
    logic [FRM_W-1:0]    frames_d;
    logic                latch_d, valid_d, sof_d, eof_d, busy_d;

    // cnt_q counts cycles since the last pop (in PRESENT/GAP) or since SETTLE entry
    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and next-output decode; outputs are registered alongside state
    always_comb begin
        state_d       = state_q;
        flush_frame_d = flush_frame_q;
        idx_d         = idx_q;
        rem_d         = rem_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        hold_d        = out_data;
        frames_d      = frames_sent;

        case (state_q)
            IDLE: begin
                if (fifo_frame_valid) begin
                    state_d       = CAPTURE;
                    flush_frame_d = flush;
                end
            end
            CAPTURE: begin
                hold_d = fifo_data;
                cnt_d  = CNT_W'(1);
                if (idx_q == 8'd2) begin
                    rem_d  = fifo_data;
                    last_d = (fifo_data == 8'd0);
                end else if (idx_q >= 8'd3) begin
                    rem_d  = rem_q - 8'd1;
                    last_d = (rem_q == 8'd1);
                end else begin
                    last_d = 1'b0;
                end
                state_d = PRESENT;
            end
            PRESENT: begin
                cnt_d = cnt_sat;
                if ((out_valid && out_ready) || flush_frame_q) begin
                    idx_d = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
                    if (last_q) begin
                        state_d  = SETTLE;
                        cnt_d    = '0;
                        frames_d = frames_sent + FRM_W'(1);
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_sat;
                if (cnt_sat >= RL_THR) begin
                    state_d = CAPTURE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_sat;
                if (cnt_sat >= SETTLE_THR) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    rem_d   = '0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        latch_d = (state_d == CAPTURE);
        valid_d = (state_d == PRESENT) && !flush_frame_d;
        sof_d   = valid_d && (idx_d == 8'd0);
        eof_d   = valid_d && last_d;
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            flush_frame_q   <= 1'b0;
            idx_q           <= '0;
            rem_q           <= '0;
            last_q          <= 1'b0;
            cnt_q           <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_sof         <= 1'b0;
            out_eof         <= 1'b0;
            fifo_data_latch <= 1'b0;
            busy            <= 1'b0;
            frames_sent     <= '0;
        end else begin
            state_q         <= state_d;
            flush_frame_q   <= flush_frame_d;
            idx_q           <= idx_d;
            rem_q           <= rem_d;
            last_q          <= last_d;
            cnt_q           <= cnt_d;
            out_data        <= hold_d;
            out_valid       <= valid_d;
            out_sof         <= sof_d;
            out_eof         <= eof_d;
            fifo_data_latch <= latch_d;
            busy            <= busy_d;
            frames_sent     <= frames_d;
        end
    end

endmodule
